// File: rtl/obi_mem_arbiter.sv
// Two-master to one-slave OBI arbiter. Data master has priority, the instruction master has a starvation guard.
// Responses are routed back to their issuer through an in-order ID FIFO.
module obi_mem_arbiter #(
    parameter int unsigned OUTSTANDING  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        s_req_o,
    input  logic        s_gnt_i,
    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,
    output logic        err_o
);
    localparam int unsigned CW = $clog2(OUTSTANDING + 1);
    localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH      = CW'(OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR   = PW'(OUTSTANDING - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic                   lock_valid_q, lock_valid_d;
    logic                   lock_id_q, lock_id_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [OUTSTANDING-1:0] id_q;
    logic [SW-1:0]          starve_q, starve_d;
    logic                   err_q, err_d;

    logic sel, sel_req, req_int, hs, pop, head_id;

    // sel: 0 selects the instruction master, 1 the data master
    always_comb begin
        sel     = 1'b0;
        sel_req = 1'b0;
        if (lock_valid_q) begin
            sel     = lock_id_q;
            sel_req = lock_id_q ? m1_req_i : m0_req_i;
        end else if (m0_req_i && (starve_q >= STARVE_MAX)) begin
            sel     = 1'b0;
            sel_req = 1'b1;
        end else if (m1_req_i) begin
            sel     = 1'b1;
            sel_req = 1'b1;
        end else if (m0_req_i) begin
            sel     = 1'b0;
            sel_req = 1'b1;
        end
    end

    // A full FIFO blocks new requests even if a response arrives this cycle
    assign req_int = rst_ni & sel_req & (count_q < DEPTH);
    assign hs      = req_int & s_gnt_i;
    assign pop     = s_rvalid_i & (count_q != '0);
    assign head_id = id_q[rd_ptr_q];

    always_comb begin
        lock_valid_d = req_int & ~s_gnt_i;
        lock_id_d    = (req_int & ~s_gnt_i) ? sel : lock_id_q;

        count_d = count_q;
        if (hs && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!hs && pop) begin
            count_d = count_q - 1'b1;
        end

        wr_ptr_d = wr_ptr_q;
        if (hs) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end

        starve_d = '0;
        if (m0_req_i && !(hs && !sel)) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
        end

        err_d = err_q | (s_rvalid_i & (count_q == '0));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_valid_q <= 1'b0;
            lock_id_q    <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            starve_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            starve_q     <= starve_d;
            err_q        <= err_d;
        end
    end

    // ID storage carries no reset; only entries between the pointers are ever read
    always_ff @(posedge clk_i) begin
        if (hs) begin
            id_q[wr_ptr_q] <= sel;
        end
    end

    always_comb begin
        s_req_o     = req_int;
        s_addr_o    = '0;
        s_we_o      = 1'b0;
        s_be_o      = '0;
        s_wdata_o   = '0;
        if (req_int) begin
            s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
            s_we_o    = sel ? m1_we_i    : m0_we_i;
            s_be_o    = sel ? m1_be_i    : m0_be_i;
            s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
        end
        m0_gnt_o    = hs & ~sel;
        m1_gnt_o    = hs & sel;
        m0_rvalid_o = pop & ~head_id;
        m1_rvalid_o = pop & head_id;
        m0_rdata_o  = rst_ni ? s_rdata_i : '0;
        m1_rdata_o  = rst_ni ? s_rdata_i : '0;
        err_o       = err_q;
    end

endmodule
